pipelined_csel_adder: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor for the structural ALU datapath.

---
 rtl/padd_pkg.sv | 20 ++
 rtl/csel_block.sv | 33 +++
 rtl/pipelined_csel_adder.sv | 162 ++++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padd_pkg.sv
// padd_pkg: shared types, default geometry and helpers for the pipelined
// carry-select adder/subtractor used by the structural ALU datapath.
package padd_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } padd_op_e;

   // Default geometry shared with the ALU top
   localparam int PADD_WIDTH  = 32;
   localparam int PADD_BLK    = 4;
   localparam int PADD_STAGES = 2;

   // Number of carry-select blocks covering the magnitude bits
   function automatic int nblk(input int width, input int blk);
      return width / blk;
   endfunction

endpackage

// File: rtl/csel_block.sv
// csel_block: one carry-select slice. Two BLK-bit ripple adders run in
// parallel with carry-in 0 and 1; the real carry-in only drives the final mux,
// so the block's critical path is a single mux once the carry arrives.
module csel_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] sum,
   output logic           cout
);

   logic [BLK:0]   c0;
   logic [BLK:0]   c1;
   logic [BLK-1:0] s0;
   logic [BLK-1:0] s1;

   assign c0[0] = 1'b0;
   assign c1[0] = 1'b1;

   genvar gi;
   for (gi = 0; gi < BLK; gi++) begin : gen_bit
      assign s0[gi]    = a[gi] ^ b[gi] ^ c0[gi];
      assign c0[gi+1]  = (a[gi] & b[gi]) | (c0[gi] & (a[gi] ^ b[gi]));
      assign s1[gi]    = a[gi] ^ b[gi] ^ c1[gi];
      assign c1[gi+1]  = (a[gi] & b[gi]) | (c1[gi] & (a[gi] ^ b[gi]));
   end

   assign sum  = cin ? s1 : s0;
   assign cout = cin ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: WIDTH+1-bit two's complement adder/subtractor built
// from BLK-bit carry-select blocks spread evenly over STAGES register stages.
// The sign bit is a single full adder in the last stage, which also produces
// the cout/ovf/zero flags. The whole pipe advances as one unit on
// adv = !out_valid | out_ready.
// Optional feature: define PADD_SAT_EN to clamp the sum on signed overflow.
module pipelined_csel_adder
   import padd_pkg::*;
#(
   parameter int WIDTH  = PADD_WIDTH,
   parameter int BLK    = PADD_BLK,
   parameter int STAGES = PADD_STAGES
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  padd_op_e       op,
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           cin,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [WIDTH:0] sum,
   output logic           cout,
   output logic           ovf,
   output logic           zero
);

   localparam int NBLK = nblk(WIDTH, BLK);
   localparam int BPS  = NBLK / STAGES;   // blocks resolved per stage
   localparam int SW   = BPS * BLK;       // bits resolved per stage
   localparam int LAST = STAGES - 1;

   logic           adv;
   logic [WIDTH:0] b_eff;
   logic           c_eff;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is a + ~b + !cin, so a borrow-in becomes an inverted carry-in
   assign b_eff = (op == OP_SUB) ? ~b : b;
   assign c_eff = (op == OP_SUB) ? ~cin : cin;

   genvar gi, gj;
   for (gi = 0; gi < STAGES; gi++) begin : gen_stg
      localparam int LO  = gi * SW;           // sum bits already resolved
      localparam int OPW = WIDTH + 1 - LO;    // operand bits still pending

      logic [OPW-1:0]   a_s;
      logic [OPW-1:0]   b_s;
      logic             c_s;
      logic             v_s;
      logic [SW-1:0]    blk_sum;
      logic [BPS:0]     cy;
      logic [LO+SW-1:0] res_s;

      if (gi == 0) begin : g_src
         assign a_s   = a;
         assign b_s   = b_eff;
         assign c_s   = c_eff;
         assign v_s   = in_valid;
         assign res_s = blk_sum;
      end else begin : g_src
         assign a_s   = gen_stg[gi-1].g_reg.a_reg;
         assign b_s   = gen_stg[gi-1].g_reg.b_reg;
         assign c_s   = gen_stg[gi-1].g_reg.carry_reg;
         assign v_s   = gen_stg[gi-1].g_reg.valid_reg;
         assign res_s = {blk_sum, gen_stg[gi-1].g_reg.sum_reg};
      end

      assign cy[0] = c_s;

      for (gj = 0; gj < BPS; gj++) begin : gen_blk
         csel_block #(.BLK(BLK)) u_blk (
            .a    (a_s[gj*BLK +: BLK]),
            .b    (b_s[gj*BLK +: BLK]),
            .cin  (cy[gj]),
            .sum  (blk_sum[gj*BLK +: BLK]),
            .cout (cy[gj+1])
         );
      end

      if (gi < LAST) begin : g_reg
         logic [OPW-SW-1:0] a_reg;
         logic [OPW-SW-1:0] b_reg;
         logic [LO+SW-1:0]  sum_reg;
         logic              carry_reg;
         logic              valid_reg;

         // Stage valid: cleared by reset, otherwise follows the pipe advance
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg <= 1'b0;
            end else if (adv) begin
               valid_reg <= v_s;
            end
         end

         // Stage data: resolved low bits, boundary carry, unconsumed operands
         always_ff @(posedge clk) begin
            if (adv) begin
               a_reg     <= a_s[OPW-1:SW];
               b_reg     <= b_s[OPW-1:SW];
               sum_reg   <= res_s;
               carry_reg <= cy[BPS];
            end
         end
      end
   end

   // Final stage: sign full adder and flags from the raw result
   logic           sa;
   logic           sb;
   logic           c_sign;
   logic           raw_sign;
   logic           cout_n;
   logic           ovf_n;
   logic           v_fin;
   logic [WIDTH:0] raw_sum;
   logic [WIDTH:0] fin_sum;

   assign sa       = gen_stg[LAST].a_s[SW];
   assign sb       = gen_stg[LAST].b_s[SW];
   assign c_sign   = gen_stg[LAST].cy[BPS];
   assign v_fin    = gen_stg[LAST].v_s;
   assign raw_sign = sa ^ sb ^ c_sign;
   assign cout_n   = (sa & sb) | (c_sign & (sa ^ sb));
   assign ovf_n    = c_sign ^ cout_n;
   assign raw_sum  = {raw_sign, gen_stg[LAST].res_s};

`ifdef PADD_SAT_EN
   // Clamp on overflow: a raw sign of 1 means the true result was too positive
   always_comb begin
      fin_sum = raw_sum;
      if (ovf_n) begin
         fin_sum = raw_sign ? {1'b0, {WIDTH{1'b1}}} : {1'b1, {WIDTH{1'b0}}};
      end
   end
`else
   assign fin_sum = raw_sum;
`endif

   // Output register: cleared by reset, held stable while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (adv) begin
         out_valid <= v_fin;
         sum       <= fin_sum;
         cout      <= cout_n;
         ovf       <= ovf_n;
         zero      <= (fin_sum == '0);
      end
   end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: scoreboard bench for the pipelined carry-select
// adder (WIDTH=32, BLK=4, STAGES=2). Expected results are queued when a beat
// is accepted and compared in order when a result beat is taken.
// Honours PADD_SAT_EN for the saturating build.
module tb_pipelined_csel_adder;
   import padd_pkg::*;

   localparam int W = 32;

`ifdef PADD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [W:0] sum;
      logic       cout;
      logic       ovf;
      logic       zero;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   padd_op_e   op;
   logic [W:0] a;
   logic [W:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [W:0] sum;
   logic       cout;
   logic       ovf;
   logic       zero;

   res_t exp_q[$];
   res_t next_exp;
   int   checks    = 0;
   int   failures  = 0;
   int   beats_out = 0;
   bit   last_acc  = 1'b0;

   always #5 clk = ~clk;

   pipelined_csel_adder #(.WIDTH(W), .BLK(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic res_t mk(input logic [W:0] s, input logic c, input logic o, input logic z);
      return {s, c, o, z};
   endfunction

   // Reference: wide arithmetic, overflow from operand/result signs
   function automatic res_t model(input padd_op_e o, input logic [W:0] x, input logic [W:0] y,
                                  input logic c);
      logic [W:0]   yy;
      logic         cc;
      logic [W+1:0] full;
      res_t         r;
      yy     = (o == OP_SUB) ? ~y : y;
      cc     = (o == OP_SUB) ? ~c : c;
      full   = {1'b0, x} + {1'b0, yy} + (W+2)'(cc);
      r.cout = full[W+1];
      r.sum  = full[W:0];
      r.ovf  = (x[W] == yy[W]) && (r.sum[W] != x[W]);
      if (SAT && r.ovf) begin
         r.sum = r.sum[W] ? {1'b0, {W{1'b1}}} : {1'b1, {W{1'b0}}};
      end
      r.zero = (r.sum == '0);
      return r;
   endfunction

   function automatic logic [W:0] rand_opnd();
      logic [W:0] v;
      case ($urandom_range(5))
         0:       v = '0;
         1:       v = {1'b0, {W{1'b1}}};
         2:       v = {1'b1, {W{1'b0}}};
         3:       v = {(W+1){1'b1}};
         default: v = {1'($urandom_range(1)), 32'($urandom)};
      endcase
      return v;
   endfunction

   task automatic drive(input padd_op_e o, input logic [W:0] x, input logic [W:0] y,
                        input logic c, input res_t e);
      op       = o;
      a        = x;
      b        = y;
      cin      = c;
      in_valid = 1'b1;
      next_exp = e;
   endtask

   // One clock: take a result beat, queue an accepted beat, advance to next negedge
   task automatic cycle();
      res_t e;
      #1;
      if (!rst && out_valid && out_ready) begin
         chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sum", 64'(sum), 64'(e.sum));
            chk("cout", 64'(cout), 64'(e.cout));
            chk("ovf", 64'(ovf), 64'(e.ovf));
            chk("zero", 64'(zero), 64'(e.zero));
         end
         $display("beat %0d: sum=%h cout=%b ovf=%b zero=%b", beats_out, sum, cout, ovf, zero);
         beats_out++;
      end
      last_acc = !rst && in_valid && in_ready;
      if (last_acc) exp_q.push_back(next_exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W:0] held;
      int         start;
      int         sent;
      int         guard;
      padd_op_e   ro;
      logic [W:0] ra;
      logic [W:0] rb;
      logic       rc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = OP_ADD;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      next_exp  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Carry crossing the stage boundary, with latency check
      drive(OP_ADD, 33'h0_0000_FFFF, 33'h1, 1'b0, mk(33'h0_0001_0000, 1'b0, 1'b0, 1'b0));
      cycle();
      in_valid = 1'b0;
      #1 chk("lat_1cyc_valid", 64'(out_valid), 64'd0);
      cycle();
      #1 chk("lat_2cyc_valid", 64'(out_valid), 64'd1);
      cycle();

      // Signed overflow positive, then directed subtract and edge cases
      drive(OP_ADD, 33'h0_FFFF_FFFF, 33'h1, 1'b0,
            mk(SAT ? 33'h0_FFFF_FFFF : 33'h1_0000_0000, 1'b0, 1'b1, 1'b0));
      cycle();
      drive(OP_SUB, 33'd5, 33'd7, 1'b0, mk(33'h1_FFFF_FFFE, 1'b0, 1'b0, 1'b0));
      cycle();
      drive(OP_SUB, 33'd7, 33'd7, 1'b0, mk(33'h0, 1'b1, 1'b0, 1'b1));
      cycle();
      drive(OP_SUB, 33'd7, 33'd7, 1'b1, mk(33'h1_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
      cycle();
      drive(OP_ADD, 33'h1_FFFF_FFFF, 33'h0, 1'b1, mk(33'h0, 1'b1, 1'b0, 1'b1));
      cycle();
      drive(OP_SUB, 33'h1_0000_0000, 33'h1, 1'b0,
            mk(SAT ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF, 1'b1, 1'b1, 1'b0));
      cycle();
      drain();

      // Back-pressure: four back-to-back beats, three stalled cycles
      start     = beats_out;
      out_ready = 1'b1;
      drive(OP_ADD, 33'h0_1234_5678, 33'h0_1111_1111, 1'b0,
            model(OP_ADD, 33'h0_1234_5678, 33'h0_1111_1111, 1'b0));
      cycle();
      drive(OP_SUB, 33'h0_0000_0010, 33'h0_0000_0020, 1'b1,
            model(OP_SUB, 33'h0_0000_0010, 33'h0_0000_0020, 1'b1));
      cycle();
      #1 chk("bp_first_valid", 64'(out_valid), 64'd1);
      held      = sum;
      out_ready = 1'b0;
      drive(OP_ADD, 33'h1_8000_0000, 33'h1_8000_0000, 1'b1,
            model(OP_ADD, 33'h1_8000_0000, 33'h1_8000_0000, 1'b1));
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_valid_hold", 64'(out_valid), 64'd1);
         chk("bp_sum_hold", 64'(sum), 64'(held));
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      drive(OP_SUB, 33'h0_DEAD_BEEF, 33'h1_CAFE_F00D, 1'b0,
            model(OP_SUB, 33'h0_DEAD_BEEF, 33'h1_CAFE_F00D, 1'b0));
      cycle();
      drain();
      chk("bp_count", 64'(beats_out - start), 64'd4);

      // Reset with two beats in flight: both must vanish
      drive(OP_ADD, 33'h0_0000_0001, 33'h0_0000_0002, 1'b0, mk(33'h3, 1'b0, 1'b0, 1'b0));
      cycle();
      drive(OP_ADD, 33'h0_0000_0004, 33'h0_0000_0005, 1'b0, mk(33'h9, 1'b0, 1'b0, 1'b0));
      cycle();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      cycle();
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_sum", 64'(sum), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      start     = beats_out;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("flush_no_stale", 64'(out_valid), 64'd0);
         cycle();
      end
      chk("flush_count", 64'(beats_out - start), 64'd0);

      // Random streaming with random valid/ready
      start    = beats_out;
      sent     = 0;
      guard    = 0;
      last_acc = 1'b0;
      while (sent < 10000 && guard < 60000) begin
         if (!in_valid || last_acc) begin
            if ($urandom_range(9) < 7) begin
               ro = padd_op_e'($urandom_range(1));
               ra = rand_opnd();
               rb = rand_opnd();
               rc = 1'($urandom_range(1));
               drive(ro, ra, rb, rc, model(ro, ra, rb, rc));
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(9) < 7);
         cycle();
         if (last_acc) sent++;
         guard++;
      end
      drain();
      chk("rand_sent", 64'(sent), 64'd10000);
      chk("rand_received", 64'(beats_out - start), 64'd10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
